// File: rtl/bip_pkg.sv
// Shared definitions for the BIP control unit: opcodes, datapath select encodings,
// sequencer states and the control vector driven towards the datapath.
package bip_pkg;

    localparam logic [4:0] OPC_HLT  = 5'b00000;
    localparam logic [4:0] OPC_STO  = 5'b00001;
    localparam logic [4:0] OPC_LD   = 5'b00010;
    localparam logic [4:0] OPC_LDI  = 5'b00011;
    localparam logic [4:0] OPC_ADD  = 5'b00100;
    localparam logic [4:0] OPC_ADDI = 5'b00101;
    localparam logic [4:0] OPC_SUB  = 5'b00110;
    localparam logic [4:0] OPC_SUBI = 5'b00111;

    localparam logic [1:0] ACC_SRC_DM  = 2'd0;
    localparam logic [1:0] ACC_SRC_IMM = 2'd1;
    localparam logic [1:0] ACC_SRC_ALU = 2'd2;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_MEMRD,
        ST_HALT
    } state_t;

    typedef struct packed {
        logic [1:0] sel_a;
        logic       sel_b;
        logic       op;
        logic       wr_acc;
        logic       rd_ram;
        logic       wr_ram;
    } ctrl_t;

    // Instructions that need a second cycle to consume DM_IN.
    function automatic logic is_mem_op(input logic [4:0] opcode);
        return (opcode == OPC_LD) || (opcode == OPC_ADD) || (opcode == OPC_SUB);
    endfunction

endpackage

// File: rtl/bip_decoder.sv
// Combinational control decode: maps the sequencer state and current opcode
// to the datapath selects and data-memory strobes.
module bip_decoder
    import bip_pkg::*;
(
    input  state_t     state,
    input  logic [4:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_DECODE: begin
                case (opcode)
                    OPC_STO: ctrl.wr_ram = 1'b1;
                    OPC_LDI: begin
                        ctrl.sel_a  = ACC_SRC_IMM;
                        ctrl.wr_acc = 1'b1;
                    end
                    OPC_ADDI, OPC_SUBI: begin
                        ctrl.sel_a  = ACC_SRC_ALU;
                        ctrl.sel_b  = 1'b0;
                        ctrl.op     = (opcode == OPC_SUBI) ? ALU_SUB : ALU_ADD;
                        ctrl.wr_acc = 1'b1;
                    end
                    OPC_LD, OPC_ADD, OPC_SUB: ctrl.rd_ram = 1'b1;
                    default: ctrl = '0;
                endcase
            end
            ST_MEMRD: begin
                case (opcode)
                    OPC_LD: begin
                        ctrl.sel_a  = ACC_SRC_DM;
                        ctrl.wr_acc = 1'b1;
                    end
                    OPC_ADD, OPC_SUB: begin
                        ctrl.sel_a  = ACC_SRC_ALU;
                        ctrl.sel_b  = 1'b1;
                        ctrl.op     = (opcode == OPC_SUB) ? ALU_SUB : ALU_ADD;
                        ctrl.wr_acc = 1'b1;
                    end
                    default: ctrl = '0;
                endcase
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/bip_control.sv
// BIP sequencing control: owns PC, IR and the retired-instruction counter and
// steps instructions through FETCH / DECODE / MEMRD.
module bip_control
    import bip_pkg::*;
#(
    parameter int PC_WIDTH    = 11,
    parameter int INSTR_WIDTH = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   START,
    input  logic [INSTR_WIDTH-1:0] INSTR,
    output logic [PC_WIDTH-1:0]    PM_ADDR,
    output logic [PC_WIDTH-1:0]    OPERAND,
    output logic [1:0]             SEL_A,
    output logic                   SEL_B,
    output logic                   OP,
    output logic                   WR_ACC,
    output logic                   RD_RAM,
    output logic                   WR_RAM,
    output logic                   HALTED,
    output logic [CNT_WIDTH-1:0]   RETIRED
);

    state_t                 state;
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] ir;
    logic [CNT_WIDTH-1:0]   retired;
    logic [4:0]             instr_opc;
    logic [4:0]             dec_opc;
    ctrl_t                  ctrl;

    assign instr_opc = INSTR[INSTR_WIDTH-1 -: 5];
    // INSTR is only valid during DECODE; every later cycle works from the latched IR.
    assign dec_opc   = (state == ST_DECODE) ? instr_opc : ir[INSTR_WIDTH-1 -: 5];

    bip_decoder u_decoder (
        .state  (state),
        .opcode (dec_opc),
        .ctrl   (ctrl)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= ST_IDLE;
            pc      <= '0;
            ir      <= '0;
            retired <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) state <= ST_FETCH;
                end
                ST_FETCH: state <= ST_DECODE;
                ST_DECODE: begin
                    ir <= INSTR;
                    if (is_mem_op(instr_opc)) begin
                        state <= ST_MEMRD;
                    end else begin
                        retired <= retired + CNT_WIDTH'(1);
                        if (instr_opc == OPC_HLT) begin
                            state <= ST_HALT;
                        end else begin
                            pc    <= pc + PC_WIDTH'(1);
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_MEMRD: begin
                    retired <= retired + CNT_WIDTH'(1);
                    pc      <= pc + PC_WIDTH'(1);
                    state   <= ST_FETCH;
                end
                ST_HALT: begin
                    if (START) begin
                        pc      <= '0;
                        retired <= '0;
                        state   <= ST_FETCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign PM_ADDR = pc;
    assign OPERAND = (state == ST_DECODE) ? INSTR[PC_WIDTH-1:0] : ir[PC_WIDTH-1:0];
    assign SEL_A   = ctrl.sel_a;
    assign SEL_B   = ctrl.sel_b;
    assign OP      = ctrl.op;
    assign WR_ACC  = ctrl.wr_acc;
    assign RD_RAM  = ctrl.rd_ram;
    assign WR_RAM  = ctrl.wr_ram;
    assign HALTED  = (state == ST_HALT);
    assign RETIRED = retired;

endmodule

// File: tb/tb_bip_control.sv
// Table-driven bench for bip_control with behavioural program memory, data memory
// and accumulator around it.
module tb_bip_control;

    logic        CLK;
    logic        RESET;
    logic        START;
    logic [15:0] INSTR;
    logic [10:0] PM_ADDR;
    logic [10:0] OPERAND;
    logic [1:0]  SEL_A;
    logic        SEL_B;
    logic        OP;
    logic        WR_ACC;
    logic        RD_RAM;
    logic        WR_RAM;
    logic        HALTED;
    logic [15:0] RETIRED;

    bip_control #(.PC_WIDTH(11), .INSTR_WIDTH(16), .CNT_WIDTH(16)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .START   (START),
        .INSTR   (INSTR),
        .PM_ADDR (PM_ADDR),
        .OPERAND (OPERAND),
        .SEL_A   (SEL_A),
        .SEL_B   (SEL_B),
        .OP      (OP),
        .WR_ACC  (WR_ACC),
        .RD_RAM  (RD_RAM),
        .WR_RAM  (WR_RAM),
        .HALTED  (HALTED),
        .RETIRED (RETIRED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Environment: synchronous program memory, data memory and accumulator
    logic [15:0] pm [0:2047];
    logic [15:0] dm [0:2047];
    logic [15:0] acc;
    logic [15:0] dm_in;
    logic [15:0] alu_b;
    logic        dm_load;
    logic [10:0] dm_load_addr;
    logic [15:0] dm_load_val;

    always @(posedge CLK) INSTR <= pm[PM_ADDR];

    always @(posedge CLK) begin
        if (dm_load) dm[dm_load_addr] <= dm_load_val;
        else if (RESET && WR_RAM) dm[OPERAND] <= acc;
    end

    assign alu_b = SEL_B ? dm_in : {5'b0, OPERAND};

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            acc   <= '0;
            dm_in <= '0;
        end else begin
            if (RD_RAM) dm_in <= dm[OPERAND];
            if (WR_ACC) begin
                case (SEL_A)
                    2'd0:    acc <= dm_in;
                    2'd1:    acc <= {5'b0, OPERAND};
                    default: acc <= OP ? (acc - alu_b) : (acc + alu_b);
                endcase
            end
        end
    end

    typedef struct packed {
        logic [10:0] pm_addr;
        logic [10:0] operand;
        logic [1:0]  sel_a;
        logic        sel_b;
        logic        op;
        logic        wr_acc;
        logic        rd_ram;
        logic        wr_ram;
        logic        halted;
        logic [15:0] retired;
        logic [15:0] acc;
    } obs_t;

    typedef struct {
        logic start;
        obs_t exp;
    } row_t;

    obs_t cur;
    assign cur = '{PM_ADDR, OPERAND, SEL_A, SEL_B, OP, WR_ACC, RD_RAM, WR_RAM, HALTED, RETIRED, acc};

    row_t vec[$];
    int   checks = 0;
    int   errors = 0;
    int   p2;

    function automatic row_t mk(input logic s, input int pa, input int opd, input int sa,
                                input int sb, input int op, input int wa, input int rd,
                                input int wr, input int h, input int ret, input int ac);
        row_t r;
        r.start = s;
        r.exp   = '{11'(pa), 11'(opd), 2'(sa), 1'(sb), 1'(op), 1'(wa), 1'(rd), 1'(wr),
                    1'(h), 16'(ret), 16'(ac)};
        return r;
    endfunction

    task automatic check_obs(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic run_rows(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            @(negedge CLK);
            check_obs($sformatf("row%0d", i), cur, vec[i].exp);
            START = vec[i].start;
        end
    endtask

    task automatic wait_halt(input string name);
        int n = 0;
        while (!HALTED && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check_val(name, int'(HALTED), 1);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b0;
        START = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
    endtask

    initial begin
        RESET        = 1'b0;
        START        = 1'b0;
        dm_load      = 1'b0;
        dm_load_addr = '0;
        dm_load_val  = '0;
        for (int i = 0; i < 2048; i++) pm[i] = 16'h4000;

        // Program 1: LDI 5; ADDI 3; SUBI 1; STO 10; HLT (run twice via restart)
        vec.push_back(mk(1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vec.push_back(mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vec.push_back(mk(0, 0,  5, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        vec.push_back(mk(1, 1,  5, 0, 0, 0, 0, 0, 0, 0, 1, 5));
        vec.push_back(mk(0, 1,  3, 2, 0, 0, 1, 0, 0, 0, 1, 5));
        vec.push_back(mk(0, 2,  3, 0, 0, 0, 0, 0, 0, 0, 2, 8));
        vec.push_back(mk(1, 2,  1, 2, 0, 1, 1, 0, 0, 0, 2, 8));
        vec.push_back(mk(0, 3,  1, 0, 0, 0, 0, 0, 0, 0, 3, 7));
        vec.push_back(mk(0, 3, 10, 0, 0, 0, 0, 0, 1, 0, 3, 7));
        vec.push_back(mk(0, 4, 10, 0, 0, 0, 0, 0, 0, 0, 4, 7));
        vec.push_back(mk(0, 4,  0, 0, 0, 0, 0, 0, 0, 0, 4, 7));
        vec.push_back(mk(0, 4,  0, 0, 0, 0, 0, 0, 0, 1, 5, 7));
        vec.push_back(mk(1, 4,  0, 0, 0, 0, 0, 0, 0, 1, 5, 7));
        vec.push_back(mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 7));
        vec.push_back(mk(0, 0,  5, 1, 0, 0, 1, 0, 0, 0, 0, 7));
        // Program 2: LD 4; ADD 4; SUB 4; HLT with DM[4] = 20
        p2 = vec.size();
        vec.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vec.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vec.push_back(mk(0, 0, 4, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vec.push_back(mk(0, 0, 4, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vec.push_back(mk(0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 1, 20));
        vec.push_back(mk(0, 1, 4, 0, 0, 0, 0, 1, 0, 0, 1, 20));
        vec.push_back(mk(0, 1, 4, 2, 1, 0, 1, 0, 0, 0, 1, 20));
        vec.push_back(mk(0, 2, 4, 0, 0, 0, 0, 0, 0, 0, 2, 40));
        vec.push_back(mk(0, 2, 4, 0, 0, 0, 0, 1, 0, 0, 2, 40));
        vec.push_back(mk(0, 2, 4, 2, 1, 1, 1, 0, 0, 0, 2, 40));
        vec.push_back(mk(0, 3, 4, 0, 0, 0, 0, 0, 0, 0, 3, 20));
        vec.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 3, 20));
        vec.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0, 0, 1, 4, 20));

        pm[0] = {5'b00011, 11'd5};
        pm[1] = {5'b00101, 11'd3};
        pm[2] = {5'b00111, 11'd1};
        pm[3] = {5'b00001, 11'd10};
        pm[4] = {5'b00000, 11'd0};

        repeat (3) @(negedge CLK);
        check_obs("reset_outputs", cur, '0);
        RESET = 1'b1;

        run_rows(0, 14);
        wait_halt("prog1_rerun_halt");
        check_val("prog1_acc", int'(acc), 7);
        check_val("prog1_retired", int'(RETIRED), 5);
        check_val("prog1_dm10", int'(dm[10]), 7);

        do_reset();
        pm[0] = {5'b00010, 11'd4};
        pm[1] = {5'b00100, 11'd4};
        pm[2] = {5'b00110, 11'd4};
        pm[3] = {5'b00000, 11'd0};
        pm[4] = 16'h4000;
        @(negedge CLK);
        dm_load      = 1'b1;
        dm_load_addr = 11'd4;
        dm_load_val  = 16'd20;
        @(negedge CLK);
        dm_load      = 1'b0;

        // Stop inside MEMRD of ADD, then pull reset asynchronously
        run_rows(p2, p2 + 6);
        #1 RESET = 1'b0;
        #1 check_obs("reset_in_memrd", cur, '0);
        @(negedge CLK);
        RESET = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            check_obs("idle_after_reset", cur, '0);
        end
        run_rows(p2, p2 + 12);

        // PC wrap with an all-NOP program
        do_reset();
        for (int i = 0; i < 2048; i++) pm[i] = {5'b01000, 11'(i)};
        @(negedge CLK);
        START = 1'b1;
        begin
            int n = 0;
            @(negedge CLK);
            START = 1'b0;
            n = 1;
            while (RETIRED != 16'd2048 && n < 6000) begin
                @(negedge CLK);
                n++;
            end
            check_val("wrap_cycles", n, 4097);
            check_val("wrap_retired", int'(RETIRED), 2048);
            check_val("wrap_pm_addr", int'(PM_ADDR), 0);
            check_val("wrap_halted", int'(HALTED), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
